// File: rtl/spi_slave.sv
// rtl/spi_slave.sv - SPI mode-0 slave, oversampled by clk, one buffered tx byte per frame
// Receives MSB-first frames into rx_data with a one-cycle rx_valid strobe.
module spi_slave #(
  parameter int                DATA_W      = 8,
  parameter int                SYNC_STAGES = 2,
  parameter logic [DATA_W-1:0] IDLE_BYTE   = 8'hFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sck,
  input  logic              ss_n,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_wr,
  output logic              tx_ready
);

  localparam int CNT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t                 state_q;
  logic [SYNC_STAGES-1:0] sck_sync_q, ss_sync_q, mosi_sync_q;
  logic                   sck_prev_q, ss_prev_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   load_pend_q;
  logic [DATA_W-2:0]      rx_shift_q;
  logic [DATA_W-1:0]      rx_shift_d;
  logic [DATA_W-1:0]      tx_shift_q, tx_buf_q, rx_data_q, load_byte;
  logic                   tx_full_q, rx_valid_q, miso_oe_q;
  logic                   sck_s, ss_s, mosi_s;
  logic                   sck_rise, sck_fall, ss_rise, ss_fall;

  assign sck_s    = sck_sync_q[SYNC_STAGES-1];
  assign ss_s     = ss_sync_q[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_prev_q;
  assign sck_fall = ~sck_s & sck_prev_q;
  assign ss_rise  = ss_s & ~ss_prev_q;
  assign ss_fall  = ~ss_s & ss_prev_q;

  assign rx_shift_d = {rx_shift_q, mosi_s};
  assign load_byte  = tx_full_q ? tx_buf_q : IDLE_BYTE;

  // miso idles high whenever the driver is disabled
  assign miso     = miso_oe_q ? tx_shift_q[DATA_W-1] : 1'b1;
  assign miso_oe  = miso_oe_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign tx_ready = ~tx_full_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      sck_sync_q  <= '0;
      ss_sync_q   <= '1;
      mosi_sync_q <= '1;
      sck_prev_q  <= 1'b0;
      ss_prev_q   <= 1'b1;
      cnt_q       <= '0;
      load_pend_q <= 1'b0;
      rx_shift_q  <= '0;
      tx_shift_q  <= '0;
      tx_buf_q    <= '0;
      tx_full_q   <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      miso_oe_q   <= 1'b0;
    end else begin
      sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], sck};
      ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], ss_n};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
      sck_prev_q  <= sck_s;
      ss_prev_q   <= ss_s;
      rx_valid_q  <= 1'b0;

      // A write racing a load into an empty buffer lands in tx_buf; the load uses IDLE_BYTE.
      if (tx_wr && !tx_full_q) begin
        tx_buf_q  <= tx_data;
        tx_full_q <= 1'b1;
      end

      case (state_q)
        IDLE: begin
          miso_oe_q   <= 1'b0;
          cnt_q       <= '0;
          load_pend_q <= 1'b0;
          if (ss_fall) begin
            tx_shift_q <= load_byte;
            miso_oe_q  <= 1'b1;
            if (tx_full_q) tx_full_q <= 1'b0;
            state_q    <= ACTIVE;
          end
        end
        ACTIVE: begin
          if (ss_rise) begin
            state_q     <= IDLE;
            miso_oe_q   <= 1'b0;
            cnt_q       <= '0;
            load_pend_q <= 1'b0;
          end else if (sck_rise) begin
            rx_shift_q <= rx_shift_d[DATA_W-2:0];
            if (cnt_q == CNT_LAST) begin
              cnt_q       <= '0;
              rx_data_q   <= rx_shift_d;
              rx_valid_q  <= 1'b1;
              load_pend_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end else if (sck_fall) begin
            if (load_pend_q) begin
              tx_shift_q  <= load_byte;
              load_pend_q <= 1'b0;
              if (tx_full_q) tx_full_q <= 1'b0;
            end else begin
              tx_shift_q <= {tx_shift_q[DATA_W-2:0], 1'b0};
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_slave.sv
// tb/tb_spi_slave.sv - directed bench for spi_slave with a frame-level reference model
module tb_spi_slave;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sck = 1'b0;
  logic       ss_n = 1'b1;
  logic       mosi = 1'b1;
  logic       tx_wr = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       miso, miso_oe, rx_valid, tx_ready;
  logic [7:0] rx_data;

  always #5 clk = ~clk;

  spi_slave #(.DATA_W(8), .SYNC_STAGES(2), .IDLE_BYTE(8'hFF)) dut (
    .clk(clk), .rst(rst), .sck(sck), .ss_n(ss_n), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_wr(tx_wr), .tx_ready(tx_ready)
  );

  int passed = 0;
  int total  = 0;

  // Reference model: bytes the master has sent, last delivered byte, one-deep tx buffer
  logic [7:0] rx_exp_q[$];
  logic [7:0] rx_last    = 8'h00;
  logic       model_full = 1'b0;
  logic [7:0] model_buf  = 8'h00;
  logic       mon_en     = 1'b0;
  logic       ss_seen    = 1'b1;
  int         ss_age     = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic tx_write(input logic [7:0] d);
    tx_data = d;
    tx_wr   = 1'b1;
    tick(1);
    tx_wr   = 1'b0;
    if (!model_full) begin
      model_full = 1'b1;
      model_buf  = d;
    end
  endtask

  task automatic next_tx(output logic [7:0] b);
    b = model_full ? model_buf : 8'hFF;
    model_full = 1'b0;
  endtask

  // Master side, sck = clk/8: mosi changes with sck low, miso sampled at the rise
  task automatic shift_bits(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
    mi = 8'h00;
    for (int i = 7; i >= 8 - nbits; i--) begin
      mosi = mo[i];
      tick(4);
      mi[i] = miso;
      sck = 1'b1;
      tick(4);
      sck = 1'b0;
    end
  endtask

  task automatic frame(input logic [7:0] mo, output logic [7:0] mi, output logic [7:0] em);
    next_tx(em);
    rx_exp_q.push_back(mo);
    shift_bits(mo, 8, mi);
  endtask

  task automatic select_slave();
    ss_n = 1'b0;
    tick(8);
  endtask

  task automatic deselect_slave();
    tick(4);
    ss_n = 1'b1;
    tick(8);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (rx_valid) begin
        if (rx_exp_q.size() == 0) begin
          check("rx_valid_unexpected", rx_valid, 1'b0);
        end else begin
          rx_last = rx_exp_q.pop_front();
          check("rx_data_strobe", rx_data, rx_last);
        end
      end else begin
        check("rx_data_hold", rx_data, rx_last);
      end
      if (ss_n !== ss_seen) begin
        ss_seen = ss_n;
        ss_age  = 0;
      end else if (ss_age < 1000) begin
        ss_age++;
      end
      if (ss_age >= 4 && !rst) begin
        check("miso_oe", miso_oe, !ss_n);
        if (ss_n) begin
          check("miso_idle", miso, 1'b1);
          check("tx_ready", tx_ready, !model_full);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] mi, em;

    rst = 1'b1;
    tick(3);
    check("rst_miso_oe", miso_oe, 1'b0);
    check("rst_miso", miso, 1'b1);
    check("rst_rx_valid", rx_valid, 1'b0);
    check("rst_tx_ready", tx_ready, 1'b1);
    check("rst_rx_data", rx_data, 8'h00);
    rst = 1'b0;
    mon_en = 1'b1;
    tick(4);

    // Single frame with a buffered tx byte
    tx_write(8'hA5);
    check("t2_tx_ready_full", tx_ready, 1'b0);
    select_slave();
    frame(8'h3C, mi, em);
    check("t2_model_tx", em, 8'hA5);
    check("t2_master_rx", mi, em);
    deselect_slave();
    check("t2_rx_data", rx_data, 8'h3C);
    check("t2_tx_ready", tx_ready, 1'b1);
    check("t2_rx_pending", rx_exp_q.size(), 0);

    // Two back-to-back frames, empty tx buffer
    select_slave();
    frame(8'h01, mi, em);
    check("t3_master_rx0", mi, em);
    check("t3_master_rx0_lit", mi, 8'hFF);
    frame(8'h80, mi, em);
    check("t3_master_rx1", mi, em);
    check("t3_master_rx1_lit", mi, 8'hFF);
    deselect_slave();
    check("t3_rx_data", rx_data, 8'h80);
    check("t3_rx_pending", rx_exp_q.size(), 0);

    // Abort after 5 rises, then a full frame
    select_slave();
    next_tx(em);
    shift_bits(8'hF0, 5, mi);
    deselect_slave();
    check("t4_miso_oe", miso_oe, 1'b0);
    check("t4_rx_data_kept", rx_data, 8'h80);
    select_slave();
    frame(8'hC3, mi, em);
    check("t4_master_rx", mi, em);
    deselect_slave();
    check("t4_rx_data", rx_data, 8'hC3);
    check("t4_rx_pending", rx_exp_q.size(), 0);

    // Second write while the buffer is full is dropped
    tx_write(8'h11);
    check("t5_tx_ready_a", tx_ready, 1'b0);
    tx_write(8'h22);
    check("t5_tx_ready_b", tx_ready, 1'b0);
    select_slave();
    frame(8'h77, mi, em);
    check("t5_model_tx", em, 8'h11);
    check("t5_master_rx", mi, em);
    deselect_slave();
    select_slave();
    frame(8'h66, mi, em);
    check("t5_master_rx2", mi, 8'hFF);
    deselect_slave();
    check("t5_rx_data", rx_data, 8'h66);

    // Reset after 3 rises, then a clean frame
    tx_write(8'h3E);
    select_slave();
    next_tx(em);
    shift_bits(8'h99, 3, mi);
    check("t6_master_partial", mi[7:5], em[7:5]);
    rst  = 1'b1;
    ss_n = 1'b1;
    sck  = 1'b0;
    mosi = 1'b1;
    tick(1);
    rx_exp_q.delete();
    rx_last    = 8'h00;
    model_full = 1'b0;
    check("t6_miso_oe", miso_oe, 1'b0);
    check("t6_miso", miso, 1'b1);
    check("t6_rx_valid", rx_valid, 1'b0);
    check("t6_tx_ready", tx_ready, 1'b1);
    check("t6_rx_data", rx_data, 8'h00);
    rst = 1'b0;
    tick(8);
    select_slave();
    frame(8'h5A, mi, em);
    check("t6_master_rx", mi, 8'hFF);
    deselect_slave();
    check("t6_rx_data_final", rx_data, 8'h5A);
    check("t6_rx_pending", rx_exp_q.size(), 0);

    mon_en = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
